// File: rtl/alu_iter_unit.sv
// Iterative ALU stage between the 8x8 register file read ports and its write port.
// Latency: START edge to WB edge = 1 (MOV/ADD/AND/OR), 8 (MUL), max(1, min(amt,8)) (shifts).
// Backpressure: none; START is accepted only in IDLE, and is dropped (never queued) while busy.
// Ports:
//   i_clk, i_reset (sync, active-low)   clock and reset
//   i_start, i_op, i_data1, i_data2     request, opcode, operands (shift amount = i_data2[3:0])
//   i_dest                              destination register, echoed on o_write_addr at WB
//   o_busy, o_done                      busy in EXEC/WB, one-cycle done pulse in WB
//   o_result, o_zero                    result and zero flag, updated on entering WB and held
//   o_write_en, o_write_addr            one-cycle register-file write strobe and address
module alu_iter_unit #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [WIDTH-1:0]      i_data1,
  input  logic [WIDTH-1:0]      i_data2,
  input  logic [ADDR_WIDTH-1:0] i_dest,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [WIDTH-1:0]      o_result,
  output logic                  o_write_en,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic                  o_zero
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t                  r_state;
  logic [2:0]              r_op;
  logic [WIDTH-1:0]        r_a;      // operand A, and the working value for shifts
  logic [WIDTH-1:0]        r_b;      // operand B, shifted right one bit per MUL step
  logic [2*WIDTH-1:0]      r_pp;     // MUL partial product
  logic [2*WIDTH-1:0]      r_mcand;  // MUL multiplicand, shifted left one bit per step
  logic [3:0]              r_cnt;    // EXEC cycles remaining, including the current one
  logic [3:0]              r_steps;  // real shift steps remaining (0 for amount 0)
  logic [ADDR_WIDTH-1:0]   r_dest;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_we;
  logic [WIDTH-1:0]        r_result;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic                    r_zero;

  logic [3:0]              w_steps;
  logic [2*WIDTH-1:0]      w_pp_next;
  logic [WIDTH-1:0]        w_sh_next;
  logic [WIDTH-1:0]        w_alu;
  logic                    w_is_shift;

  // Amounts above 8 saturate: eight one-bit steps already flush every bit.
  assign w_steps    = (i_data2[3:0] > 4'd8) ? 4'd8 : i_data2[3:0];
  assign w_is_shift = (i_op == OP_SLL) || (i_op == OP_SRL) || (i_op == OP_SRA);
  assign w_pp_next  = r_b[0] ? (r_pp + r_mcand) : r_pp;

  always_comb begin
    w_sh_next = r_a;
    // Amount 0 still spends one EXEC cycle, but that cycle leaves the value untouched.
    if (r_steps != 4'd0) begin
      case (r_op)
        OP_SLL:  w_sh_next = {r_a[WIDTH-2:0], 1'b0};
        OP_SRL:  w_sh_next = {1'b0, r_a[WIDTH-1:1]};
        OP_SRA:  w_sh_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        default: w_sh_next = r_a;
      endcase
    end
  end

  // Value the current EXEC step produces; only committed on the final step.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_MOV:  w_alu = r_b;
      OP_ADD:  w_alu = r_a + r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_MUL:  w_alu = w_pp_next[WIDTH-1:0];
      default: w_alu = w_sh_next;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MOV;
      r_a      <= '0;
      r_b      <= '0;
      r_pp     <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_steps  <= '0;
      r_dest   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_result <= '0;
      r_waddr  <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_data1;
            r_b     <= i_data2;
            r_dest  <= i_dest;
            r_pp    <= '0;
            r_mcand <= {{WIDTH{1'b0}}, i_data1};
            r_steps <= w_is_shift ? w_steps : 4'd0;
            if (i_op == OP_MUL)
              r_cnt <= 4'd8;
            else if (w_is_shift && (w_steps != 4'd0))
              r_cnt <= w_steps;
            else
              r_cnt <= 4'd1;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt   <= r_cnt - 4'd1;
          r_steps <= (r_steps != 4'd0) ? (r_steps - 4'd1) : 4'd0;
          r_a     <= w_sh_next;
          if (r_op == OP_MUL) begin
            r_pp    <= w_pp_next;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
          end
          if (r_cnt == 4'd1) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_waddr  <= r_dest;
            r_we     <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_WB: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_result     = r_result;
  assign o_write_en   = r_we;
  assign o_write_addr = r_waddr;
  assign o_zero       = r_zero;

endmodule

// File: tb/tb_alu_iter_unit.sv
module tb_alu_iter_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] d1, d2;
  logic [2:0] dest;
  logic       busy, done, we, zero;
  logic [7:0] result;
  logic [2:0] waddr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_iter_unit #(.WIDTH(8), .ADDR_WIDTH(3)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_op         (op),
    .i_data1      (d1),
    .i_data2      (d2),
    .i_dest       (dest),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_write_en   (we),
    .o_write_addr (waddr),
    .o_zero       (zero)
  );

  // Reference result: plain integer arithmetic, low byte kept.
  function automatic logic [7:0] ref_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int n;
    int s;
    n = int'(b[3:0]);
    case (o)
      3'd0:    s = int'(b);
      3'd1:    s = int'(a) + int'(b);
      3'd2:    s = int'(a & b);
      3'd3:    s = int'(a | b);
      3'd4:    s = int'(a) * int'(b);
      3'd5:    s = int'(a) << n;
      3'd6:    s = int'(a) >> n;
      default: begin s = int'($signed(a)); s = s >>> n; end
    endcase
    return s[7:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [7:0] b);
    int n;
    n = int'(b[3:0]);
    if (o < 3'd4)  return 1;
    if (o == 3'd4) return 8;
    if (n == 0)    return 1;
    return (n > 8) ? 8 : n;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from an IDLE negedge; returns at an IDLE negedge.
  // poke > 0: pulse START with other operands on that EXEC cycle (must be ignored).
  // wb_start: assert START during the WB cycle (must be ignored).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] d, input int poke, input bit wb_start);
    logic [7:0] er;
    int         el;
    int         cyc;
    bit         seen;
    er = ref_res(o, a, b);
    el = ref_lat(o, b);
    start = 1'b1; op = o; d1 = a; d2 = b; dest = d;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); dest = 3'($urandom);
    @(negedge clk);
    chk({tag, "_busy_exec"}, 16'(busy), 16'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
      @(negedge clk);
      if (we) seen = 1'b1;
      else begin
        chk({tag, "_busy_hold"}, 16'(busy), 16'd1);
        if (cyc == poke) begin
          start = 1'b1; op = 3'd4; d1 = 8'd3; d2 = 8'd5; dest = ~d;
        end
      end
    end
    chk({tag, "_wb_seen"}, 16'(seen), 16'd1);
    chk({tag, "_latency"}, 16'(cyc), 16'(el));
    chk({tag, "_result"}, 16'(result), 16'(er));
    chk({tag, "_zero"}, 16'(zero), 16'(er == 8'h00));
    chk({tag, "_waddr"}, 16'(waddr), 16'(d));
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_busy_wb"}, 16'(busy), 16'd1);
    if (wb_start) begin
      start = 1'b1; op = 3'd3; d1 = 8'h0F; d2 = 8'hF0; dest = ~d;
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_we_drop"}, {15'd0, we}, 16'd0);
    chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_result_held"}, 16'(result), 16'(er));
    chk({tag, "_zero_held"}, 16'(zero), 16'(er == 8'h00));
  endtask

  initial begin
    int we_cnt;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; d1 = 8'd0; d2 = 8'd0; dest = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   16'(busy),   16'd0);
    chk("rst_done",   16'(done),   16'd0);
    chk("rst_we",     16'(we),     16'd0);
    chk("rst_zero",   16'(zero),   16'd0);
    chk("rst_result", 16'(result), 16'd0);
    chk("rst_waddr",  16'(waddr),  16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op("add_wrap", 3'd1, 8'hFF, 8'h01, 3'd5, 0, 1'b0);
    run_op("mul_13x11", 3'd4, 8'd13, 8'd11, 3'd2, 0, 1'b0);
    run_op("mul_20x15", 3'd4, 8'd20, 8'd15, 3'd6, 0, 1'b0);
    run_op("sra_3", 3'd7, 8'h90, 8'd3, 3'd1, 0, 1'b0);
    run_op("sra_9", 3'd7, 8'h90, 8'd9, 3'd3, 0, 1'b0);
    run_op("sll_1", 3'd5, 8'h81, 8'd1, 3'd4, 0, 1'b0);
    run_op("srl_0", 3'd6, 8'h81, 8'd0, 3'd7, 0, 1'b0);
    run_op("srl_15", 3'd6, 8'hFF, 8'd15, 3'd0, 0, 1'b0);
    run_op("mul_poke", 3'd4, 8'd7, 8'd9, 3'd5, 3, 1'b0);
    run_op("mov_wbstart", 3'd0, 8'h11, 8'h00, 3'd2, 0, 1'b1);
    run_op("or_after", 3'd3, 8'h0F, 8'hF0, 3'd6, 0, 1'b0);

    // Reset during EXEC cycle 4 of a MUL.
    start = 1'b1; op = 3'd4; d1 = 8'd13; d2 = 8'd11; dest = 3'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy",   16'(busy),   16'd0);
    chk("abort_result", 16'(result), 16'd0);
    chk("abort_waddr",  16'(waddr),  16'd0);
    rst_n = 1'b1;
    we_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (we) we_cnt++;
    end
    chk("abort_no_we", 16'(we_cnt), 16'd0);
    run_op("after_abort", 3'd1, 8'd100, 8'd55, 3'd1, 0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             3'($urandom), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
